// File: rtl/instr_encoder_pkg.sv
// Shared opcodes, funct codes, FSM states and helpers for the RV32I instruction encoder.
package instr_encoder_pkg;

  localparam logic [6:0] R_FORMAT       = 7'b0110011;
  localparam logic [6:0] I_COMP_FORMAT  = 7'b0010011;
  localparam logic [6:0] I_LOAD_FORMAT  = 7'b0000011;
  localparam logic [6:0] S_FORMAT       = 7'b0100011;
  localparam logic [6:0] B_FORMAT       = 7'b1100011;
  localparam logic [6:0] J_FORMAT       = 7'b1101111;
  localparam logic [6:0] U_FORMAT_LUI   = 7'b0110111;
  localparam logic [6:0] U_FORMAT_AUIPC = 7'b0010111;

  localparam logic [2:0] ENC_ADDI_FUNCT3 = 3'b000;

  typedef enum logic {
    ENC_ST_RUN = 1'b0,
    ENC_ST_LI2 = 1'b1
  } enc_state_e;

  // True when v is representable as a two's-complement value of 'bits' bits.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic [31:0] t;
    t = $signed(v) >>> (bits - 1);
    return (t == '0) || (t == '1);
  endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational field packer: opcode + register/funct fields + immediate -> RV32I word.
// Optional range/alignment checking is built when ENC_RANGE_CHECK_EN is defined.
module instr_field_pack
  import instr_encoder_pkg::*;
(
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] instr_o,
  output logic        err_o
);

  // Scatter the immediate into the bit layout of the selected format.
  always_comb begin
    instr_o = '0;
    case (opcode_i)
      R_FORMAT:
        instr_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      I_COMP_FORMAT, I_LOAD_FORMAT:
        instr_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
      S_FORMAT:
        instr_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
      B_FORMAT:
        instr_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                   imm_i[4:1], imm_i[11], opcode_i};
      U_FORMAT_LUI, U_FORMAT_AUIPC:
        instr_o = {imm_i[31:12], rd_i, opcode_i};
      J_FORMAT:
        instr_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
      default:
        instr_o = '0;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  // Flag immediates that the chosen format would silently truncate or misalign.
  always_comb begin
    err_o = 1'b0;
    case (opcode_i)
      R_FORMAT:
        err_o = 1'b0;
      I_COMP_FORMAT, I_LOAD_FORMAT, S_FORMAT:
        err_o = !fits_signed(imm_i, 12);
      B_FORMAT:
        err_o = !fits_signed(imm_i, 13) || imm_i[0];
      J_FORMAT:
        err_o = !fits_signed(imm_i, 21) || imm_i[0];
      U_FORMAT_LUI, U_FORMAT_AUIPC:
        err_o = (imm_i[11:0] != 12'h000);
      default:
        err_o = 1'b1;
    endcase
  end
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I instruction encoder with LI (LUI+ADDI) expansion and a registered output.
// Optional ENC_RANGE_CHECK_EN macro enables out_err range/alignment checking.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned LI_SKIP_ZERO_LO = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  input  logic        in_li,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last,
  output logic        out_err
);

  enc_state_e  state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic        last_q, last_d;
  logic        err_q, err_d;
  logic [4:0]  rd_q, rd_d;
  logic [11:0] lo12_q, lo12_d;

  logic        accept;
  logic        beat1_done;
  logic        li_fits;
  logic        li_two_beat;
  logic [19:0] li_hi20;

  logic [6:0]  p_op;
  logic [2:0]  p_f3;
  logic [6:0]  p_f7;
  logic [4:0]  p_rd;
  logic [4:0]  p_rs1;
  logic [4:0]  p_rs2;
  logic [31:0] p_imm;
  logic [31:0] pack_instr;
  logic        pack_err;

  assign in_ready   = (state_q == ENC_ST_RUN) && (!valid_q || out_ready);
  assign accept     = in_valid && in_ready;
  assign beat1_done = (state_q == ENC_ST_LI2) && valid_q && out_ready;

  // (in_imm + 0x800)[31:12]: adding 0x800 carries into bit 12 exactly when bit 11 is set.
  assign li_hi20     = in_imm[31:12] + {19'b0, in_imm[11]};
  assign li_fits     = fits_signed(in_imm, 12);
  assign li_two_beat = in_li && !li_fits &&
                       !((LI_SKIP_ZERO_LO != 0) && (in_imm[11:0] == 12'h000));

  // Select what the packer encodes: pending ADDI of an LI, LI first beat, or the raw request.
  always_comb begin
    p_op  = in_opcode;
    p_f3  = in_funct3;
    p_f7  = in_funct7;
    p_rd  = in_rd;
    p_rs1 = in_rs1;
    p_rs2 = in_rs2;
    p_imm = in_imm;
    if (state_q == ENC_ST_LI2) begin
      p_op  = I_COMP_FORMAT;
      p_f3  = ENC_ADDI_FUNCT3;
      p_f7  = '0;
      p_rd  = rd_q;
      p_rs1 = rd_q;
      p_rs2 = '0;
      p_imm = {{20{lo12_q[11]}}, lo12_q};
    end else if (in_li) begin
      p_f7  = '0;
      p_rs1 = '0;
      p_rs2 = '0;
      if (li_fits) begin
        p_op = I_COMP_FORMAT;
        p_f3 = ENC_ADDI_FUNCT3;
      end else begin
        p_op  = U_FORMAT_LUI;
        p_f3  = '0;
        p_imm = {li_hi20, 12'h000};
      end
    end
  end

  instr_field_pack u_pack (
    .opcode_i (p_op),
    .funct3_i (p_f3),
    .funct7_i (p_f7),
    .rd_i     (p_rd),
    .rs1_i    (p_rs1),
    .rs2_i    (p_rs2),
    .imm_i    (p_imm),
    .instr_o  (pack_instr),
    .err_o    (pack_err)
  );

  // Next-state: enter LI2 after accepting a two-beat LI, leave once beat 1 is taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ENC_ST_RUN: if (accept && li_two_beat) state_d = ENC_ST_LI2;
      ENC_ST_LI2: if (beat1_done) state_d = ENC_ST_RUN;
      default:    state_d = ENC_ST_RUN;
    endcase
  end

  // Output stage next values: load on accept or LI beat-1 handshake, drop on consume, else hold.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    last_d  = last_q;
    err_d   = err_q;
    rd_d    = rd_q;
    lo12_d  = lo12_q;
    if (state_q == ENC_ST_LI2) begin
      if (beat1_done) begin
        valid_d = 1'b1;
        instr_d = pack_instr;
        last_d  = 1'b1;
        err_d   = 1'b0;
      end
    end else if (accept) begin
      valid_d = 1'b1;
      instr_d = pack_instr;
      last_d  = !li_two_beat;
      err_d   = in_li ? 1'b0 : pack_err;
      rd_d    = in_rd;
      lo12_d  = in_imm[11:0];
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // State and output registers; reset drops any pending LI second beat.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ENC_ST_RUN;
      valid_q <= 1'b0;
      instr_q <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= '0;
      lo12_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      last_q  <= last_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      lo12_q  <= lo12_d;
    end
  end

  assign out_valid = valid_q;
  assign out_instr = instr_q;
  assign out_last  = last_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vectors, stall, back-to-back,
// reset during LI expansion, and randomized traffic against an arithmetic reference model.
module tb_instr_encoder;

  localparam int unsigned SKIP = 1;
`ifdef ENC_RANGE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_I     = 7'h13;
  localparam logic [6:0] OP_LD    = 7'h03;
  localparam logic [6:0] OP_S     = 7'h23;
  localparam logic [6:0] OP_B     = 7'h63;
  localparam logic [6:0] OP_J     = 7'h6F;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_BAD   = 7'h7F;

  logic        clock, reset;
  logic        in_valid, in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        in_li;
  logic        out_valid, out_ready;
  logic [31:0] out_instr;
  logic        out_last, out_err;

  int errors = 0;
  int checks = 0;
  logic [33:0] exp_q[$];   // {err, last, instr}

  instr_encoder #(.LI_SKIP_ZERO_LO(SKIP)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .in_li     (in_li),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_last  (out_last),
    .out_err   (out_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference encoding computed with shifts and masks on plain integers.
  function automatic logic [31:0] model_enc(input logic [6:0] op, input logic [2:0] f3,
                                            input logic [6:0] f7, input logic [4:0] rd,
                                            input logic [4:0] rs1, input logic [4:0] rs2,
                                            input logic [31:0] imm);
    int unsigned u, o, r, a, b, c, g, regs;
    u = imm; o = op; r = rd; a = rs1; b = rs2; c = f3; g = f7;
    regs = (a << 15) | (c << 12);
    case (op)
      OP_R:         return (g << 25) | (b << 20) | regs | (r << 7) | o;
      OP_I, OP_LD:  return ((u & 32'hFFF) << 20) | regs | (r << 7) | o;
      OP_S:         return (((u >> 5) & 32'h7F) << 25) | (b << 20) | regs |
                           ((u & 32'h1F) << 7) | o;
      OP_B:         return (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) |
                           (b << 20) | regs | (((u >> 1) & 32'hF) << 8) |
                           (((u >> 11) & 1) << 7) | o;
      OP_LUI, OP_AUIPC: return (u & 32'hFFFFF000) | (r << 7) | o;
      OP_J:         return (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21) |
                           (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hFF) << 12) |
                           (r << 7) | o;
      default:      return 32'h0;
    endcase
  endfunction

  function automatic logic model_err(input logic [6:0] op, input logic [31:0] imm);
    int s;
    s = imm;
    if (!CHK) return 1'b0;
    case (op)
      OP_R:               return 1'b0;
      OP_I, OP_LD, OP_S:  return (s < -2048) || (s > 2047);
      OP_B:               return (s < -4096) || (s > 4095) || imm[0];
      OP_J:               return (s < -1048576) || (s > 1048575) || imm[0];
      OP_LUI, OP_AUIPC:   return (imm & 32'hFFF) != 0;
      default:            return 1'b1;
    endcase
  endfunction

  // Append the beats a request is expected to produce.
  task automatic model_push(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [31:0] imm, input logic li);
    int s;
    int unsigned hi, lo;
    logic [31:0] lui;
    s = imm;
    if (li) begin
      if (s >= -2048 && s <= 2047) begin
        exp_q.push_back({1'b0, 1'b1, model_enc(OP_I, 3'd0, 7'd0, rd, 5'd0, 5'd0, imm)});
      end else begin
        hi  = (imm + 32'h800) >> 12;
        lo  = imm & 32'hFFF;
        lui = model_enc(OP_LUI, 3'd0, 7'd0, rd, 5'd0, 5'd0, hi << 12);
        if (SKIP != 0 && lo == 0) begin
          exp_q.push_back({1'b0, 1'b1, lui});
        end else begin
          exp_q.push_back({1'b0, 1'b0, lui});
          exp_q.push_back({1'b0, 1'b1, model_enc(OP_I, 3'd0, 7'd0, rd, rd, 5'd0, lo)});
        end
      end
    end else begin
      exp_q.push_back({model_err(op, imm), 1'b1, model_enc(op, f3, f7, rd, rs1, rs2, imm)});
    end
  endtask

  task automatic set_req(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                         input logic li);
    in_opcode = op; in_funct3 = f3; in_funct7 = 7'd0;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_li = li;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(posedge clock); @(posedge clock); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL rst_instr got=%h exp=00000000", out_instr); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_last got=%b exp=0", out_last); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", out_err); end
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", in_ready); end
    @(posedge clock); #1;
  endtask

  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        li;
    logic [31:0] e1;
    logic        l1;
    logic        er1;
    logic        two;
    logic [31:0] e2;
  } dir_t;

  task automatic test_directed;
    dir_t dv[11];
    dv[0]  = '{OP_I,   3'd0, 5'd1, 5'd0, 5'd0, 32'd5,          1'b0, 32'h00500093, 1'b1, 1'b0, 1'b0, 32'h0};
    dv[1]  = '{OP_B,   3'd0, 5'd0, 5'd1, 5'd2, 32'd8,          1'b0, 32'h00208463, 1'b1, 1'b0, 1'b0, 32'h0};
    dv[2]  = '{OP_B,   3'd0, 5'd0, 5'd1, 5'd2, 32'd7,          1'b0, 32'h00208363, 1'b1, CHK,  1'b0, 32'h0};
    dv[3]  = '{OP_LUI, 3'd0, 5'd2, 5'd0, 5'd0, 32'h12345000,   1'b0, 32'h12345137, 1'b1, 1'b0, 1'b0, 32'h0};
    dv[4]  = '{OP_LUI, 3'd0, 5'd2, 5'd0, 5'd0, 32'h12345001,   1'b0, 32'h12345137, 1'b1, CHK,  1'b0, 32'h0};
    dv[5]  = '{OP_BAD, 3'd0, 5'd3, 5'd4, 5'd5, 32'h0,          1'b0, 32'h00000000, 1'b1, CHK,  1'b0, 32'h0};
    dv[6]  = '{7'd0,   3'd0, 5'd5, 5'd0, 5'd0, 32'd7,          1'b1, 32'h00700293, 1'b1, 1'b0, 1'b0, 32'h0};
    dv[7]  = '{7'd0,   3'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF,   1'b1, 32'h123462B7, 1'b0, 1'b0, 1'b1, 32'hFFF28293};
    dv[8]  = '{7'd0,   3'd0, 5'd5, 5'd0, 5'd0, 32'h12345000,   1'b1, 32'h123452B7, 1'b1, 1'b0, 1'b0, 32'h0};
    dv[9]  = '{7'd0,   3'd0, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF,   1'b1, 32'hFFF00293, 1'b1, 1'b0, 1'b0, 32'h0};
    dv[10] = '{7'd0,   3'd0, 5'd5, 5'd0, 5'd0, 32'h00000800,   1'b1, 32'h000012B7, 1'b0, 1'b0, 1'b1, 32'h80028293};
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      set_req(dv[i].op, dv[i].f3, dv[i].rd, dv[i].rs1, dv[i].rs2, dv[i].imm, dv[i].li);
      in_valid = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_ready got=%b exp=1", i, in_ready); end
      @(posedge clock); #1;
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dir%0d_valid got=%b exp=1", i, out_valid); end
      checks++; if (out_instr !== dv[i].e1) begin errors++; $display("FAIL dir%0d_instr got=%h exp=%h", i, out_instr, dv[i].e1); end
      checks++; if (out_last !== dv[i].l1) begin errors++; $display("FAIL dir%0d_last got=%b exp=%b", i, out_last, dv[i].l1); end
      checks++; if (out_err !== dv[i].er1) begin errors++; $display("FAIL dir%0d_err got=%b exp=%b", i, out_err, dv[i].er1); end
      if (dv[i].two) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL dir%0d_li2_ready got=%b exp=0", i, in_ready); end
        @(posedge clock); #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dir%0d_b2_valid got=%b exp=1", i, out_valid); end
        checks++; if (out_instr !== dv[i].e2) begin errors++; $display("FAIL dir%0d_b2_instr got=%h exp=%h", i, out_instr, dv[i].e2); end
        checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL dir%0d_b2_last got=%b exp=1", i, out_last); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL dir%0d_b2_err got=%b exp=0", i, out_err); end
      end
      @(posedge clock); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_idle got=%b exp=0", i, out_valid); end
    end
  endtask

  task automatic test_stall;
    set_req(7'd0, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF, 1'b1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall%0d_valid got=%b exp=1", c, out_valid); end
      checks++; if (out_instr !== 32'h123462B7) begin errors++; $display("FAIL stall%0d_instr got=%h exp=123462b7", c, out_instr); end
      checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL stall%0d_last got=%b exp=0", c, out_last); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall%0d_ready got=%b exp=0", c, in_ready); end
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    #1;
    checks++; if (out_instr !== 32'h123462B7) begin errors++; $display("FAIL stall_rel_instr got=%h exp=123462b7", out_instr); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_rel_ready got=%b exp=0", in_ready); end
    @(posedge clock); #1;
    checks++; if (out_instr !== 32'hFFF28293) begin errors++; $display("FAIL stall_b2_instr got=%h exp=fff28293", out_instr); end
    checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL stall_b2_last got=%b exp=1", out_last); end
    @(posedge clock); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_idle got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_bb[4];
    logic [31:0] imm;
    out_ready = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) begin
        imm = $urandom_range(0, 2047);
        exp_bb[k] = model_enc(OP_I, 3'd0, 7'd0, 5'(k + 1), 5'(k + 6), 5'd0, imm);
        set_req(OP_I, 3'd0, 5'(k + 1), 5'(k + 6), 5'd0, imm, 1'b0);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (k > 0) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b%0d_valid got=%b exp=1", k, out_valid); end
        checks++; if (out_instr !== exp_bb[k-1]) begin errors++; $display("FAIL b2b%0d_instr got=%h exp=%h", k, out_instr, exp_bb[k-1]); end
      end
      if (k < 4) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b%0d_ready got=%b exp=1", k, in_ready); end
      end
      @(posedge clock); #1;
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_in_li2;
    set_req(7'd0, 3'd0, 5'd9, 5'd0, 5'd0, 32'hABCDE123, 1'b1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rli2_pre_valid got=%b exp=1", out_valid); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rli2_async_valid got=%b exp=0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL rli2_async_instr got=%h exp=00000000", out_instr); end
    out_ready = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rli2_ready got=%b exp=1", in_ready); end
    for (int c = 0; c < 2; c++) begin
      @(posedge clock); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rli2_nobeat%0d got=%b exp=0", c, out_valid); end
    end
  endtask

  task automatic test_random;
    logic [6:0]  ops[10];
    logic        pend, acc;
    logic [33:0] e;
    logic [31:0] r;
    int          si;
    ops = '{OP_R, OP_I, OP_LD, OP_S, OP_B, OP_J, OP_LUI, OP_AUIPC, OP_JALR, OP_BAD};
    exp_q.delete();
    pend = 1'b0;
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!pend) begin
        in_opcode = ops[$urandom_range(0, 9)];
        in_funct3 = 3'($urandom_range(0, 7));
        in_funct7 = 7'($urandom_range(0, 127));
        in_rd     = 5'($urandom_range(0, 31));
        in_rs1    = 5'($urandom_range(0, 31));
        in_rs2    = 5'($urandom_range(0, 31));
        in_li     = ($urandom_range(0, 3) == 0);
        r = $urandom;
        case ($urandom_range(0, 3))
          0: begin si = int'($urandom_range(0, 4400)) - 2200; in_imm = si; end
          1: in_imm = r;
          2: in_imm = r & 32'hFFFFF000;
          default: begin si = int'($urandom_range(0, 10000)) - 5000; in_imm = si; end
        endcase
        in_valid = ($urandom_range(0, 4) != 0);
        pend = in_valid;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (out_valid !== (exp_q.size() != 0)) begin
        errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_q.size() != 0);
      end
      checks++;
      if (exp_q.size() >= 2) begin
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rnd_ready_li2 cyc=%0d got=%b exp=0", cyc, in_ready); end
      end else if (in_ready !== ((exp_q.size() == 0) || out_ready)) begin
        errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, in_ready, (exp_q.size() == 0) || out_ready);
      end
      if (out_valid && out_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({out_err, out_last, out_instr} !== e) begin
          errors++; $display("FAIL rnd_beat cyc=%0d got err=%b last=%b instr=%h exp err=%b last=%b instr=%h",
                             cyc, out_err, out_last, out_instr, e[33], e[32], e[31:0]);
        end
      end
      acc = in_valid && in_ready;
      if (acc) model_push(in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm, in_li);
      @(posedge clock); #1;
      if (acc) begin pend = 1'b0; in_valid = 1'b0; end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
      #1;
      if (out_valid) begin
        e = exp_q.pop_front();
        checks++;
        if ({out_err, out_last, out_instr} !== e) begin
          errors++; $display("FAIL rnd_drain got err=%b last=%b instr=%h exp err=%b last=%b instr=%h",
                             out_err, out_last, out_instr, e[33], e[32], e[31:0]);
        end
      end
      @(posedge clock); #1;
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_drain_timeout left=%0d exp=0", exp_q.size()); end
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rnd_final_valid got=%b exp=0", out_valid); end
  endtask

  initial begin
    in_valid = 1'b0; out_ready = 1'b1;
    set_req(7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
    reset = 1'b1;
    test_reset;
    test_directed;
    test_stall;
    test_back_to_back;
    test_reset_in_li2;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
